imm_load_sequencer: RTL

Expands a 32-bit load-constant request (the `li rd, imm32` pseudo-instruction) into one or two native micro-ops: `LUI` for the upper half and `ORI` with a zero-extended lower half. It sits between the decoder/pseudo-op front end and the register-file write path of the CPU. It owns the choice between the one-op and two-op forms, the ordering of the two ops, and the valid/ready handshakes on both sides. It also presents the pre-extended 32-bit operand for each op so the ALU does not re-derive it.

---
 rtl/imm_load_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/imm_load_sequencer.sv
// ---------------------------------------------------------------------------
// imm_load_sequencer : expands li rd, imm32 into LUI and/or ORI micro-ops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_load_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_imm,
  input  logic [4:0]       req_rd,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [1:0]       uop_op,
  output logic [4:0]       uop_rd,
  output logic [4:0]       uop_rs,
  output logic [15:0]      uop_imm16,
  output logic [31:0]      uop_ext,
  output logic             uop_last,
  output logic             busy,
  output logic [CNT_W-1:0] load_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EMIT_HI = 2'd1;
  localparam logic [1:0] S_EMIT_LO = 2'd2;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LUI  = 2'b01;
  localparam logic [1:0] OP_ORI  = 2'b10;

  logic [1:0]       state_q,     state_d;
  logic [15:0]      lo_q,        lo_d;
  logic [4:0]       rd_q,        rd_d;
  logic             valid_q,     valid_d;
  logic [1:0]       op_q,        op_d;
  logic [4:0]       urd_q,       urd_d;
  logic [4:0]       urs_q,       urs_d;
  logic [15:0]      imm16_q,     imm16_d;
  logic [31:0]      ext_q,       ext_d;
  logic             last_q,      last_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic        w_accept;
  logic        w_fire;
  logic [15:0] w_req_hi;
  logic [15:0] w_req_lo;

  assign w_req_hi = req_imm[31:16];
  assign w_req_lo = req_imm[15:0];
  assign w_accept = req_valid && (state_q == S_IDLE);
  assign w_fire   = valid_q && uop_ready;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    op_d    = op_q;
    urd_d   = urd_q;
    urs_d   = urs_q;
    imm16_d = imm16_q;
    ext_d   = ext_q;
    last_d  = last_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        // rd == 0 loads are architecturally dead and are dropped here
        if (w_accept && (req_rd != 5'd0)) begin
          lo_d    = w_req_lo;
          rd_d    = req_rd;
          valid_d = 1'b1;
          urd_d   = req_rd;
          urs_d   = 5'd0;
          if (w_req_hi != 16'd0) begin
            state_d = S_EMIT_HI;
            op_d    = OP_LUI;
            imm16_d = w_req_hi;
            ext_d   = {w_req_hi, 16'd0};
            last_d  = (w_req_lo == 16'd0);
          end else begin
            state_d = S_EMIT_LO;
            op_d    = OP_ORI;
            imm16_d = w_req_lo;
            ext_d   = {16'd0, w_req_lo};
            last_d  = 1'b1;
          end
        end
      end

      S_EMIT_HI: begin
        if (w_fire) begin
          if (lo_q == 16'd0) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            op_d    = OP_NONE;
            urd_d   = 5'd0;
            urs_d   = 5'd0;
            imm16_d = 16'd0;
            ext_d   = 32'd0;
            last_d  = 1'b0;
            count_d = count_q + 1'b1;
          end else begin
            // second op ORs the low half into the value LUI just wrote
            state_d = S_EMIT_LO;
            op_d    = OP_ORI;
            urd_d   = rd_q;
            urs_d   = rd_q;
            imm16_d = lo_q;
            ext_d   = {16'd0, lo_q};
            last_d  = 1'b1;
          end
        end
      end

      S_EMIT_LO: begin
        if (w_fire) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          op_d    = OP_NONE;
          urd_d   = 5'd0;
          urs_d   = 5'd0;
          imm16_d = 16'd0;
          ext_d   = 32'd0;
          last_d  = 1'b0;
          count_d = count_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        op_d    = OP_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= 16'd0;
      rd_q    <= 5'd0;
      valid_q <= 1'b0;
      op_q    <= OP_NONE;
      urd_q   <= 5'd0;
      urs_q   <= 5'd0;
      imm16_q <= 16'd0;
      ext_q   <= 32'd0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      urd_q   <= urd_d;
      urs_q   <= urs_d;
      imm16_q <= imm16_d;
      ext_q   <= ext_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign uop_valid  = valid_q;
  assign uop_op     = op_q;
  assign uop_rd     = urd_q;
  assign uop_rs     = urs_q;
  assign uop_imm16  = imm16_q;
  assign uop_ext    = ext_q;
  assign uop_last   = last_q;
  assign load_count = count_q;

endmodule

`default_nettype wire
